// File: rtl/cla_seq_divider.sv
// Sequential unsigned restoring divider for the ALU's multi-cycle divide unit.
// One quotient bit is produced per clock.  Each trial subtraction is computed
// as T + ~D + 1 with 4-bit carry-lookahead groups rippled together, so the
// divider reuses the same arithmetic structure as the CLA adder beside it.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        request a division (accepted in IDLE or FIN)
//   dividend     unsigned dividend, captured on accept
//   divisor      unsigned divisor, captured on accept
//   busy         high while iterating (RUN)
//   done         one-cycle pulse; quotient/remainder/div_by_zero valid
//   quotient     unsigned quotient, held until the next result
//   remainder    unsigned remainder, held until the next result
//   div_by_zero  set with done when the captured divisor was zero
module cla_seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned GROUPS = WIDTH / 4;
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   d_reg;
    // Partial remainder.  After every step it is below the divisor, so its
    // conceptual top (WIDTH+1-th) bit is always zero and is not stored.
    logic [WIDTH-1:0]   r_reg;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     t_c;
    logic [WIDTH-1:0]   diff_c;
    logic               no_borrow_c;
    logic [WIDTH-1:0]   r_next_c;
    logic [WIDTH-1:0]   q_next_c;

    // Shift the next dividend bit into the partial remainder.
    assign t_c = {r_reg, q_reg[WIDTH-1]};

    // Trial subtraction T - D via 4-bit lookahead groups with inter-group ripple.
    always_comb begin : cla_sub
        logic [3:0] a4;
        logic [3:0] b4;
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       gg;
        logic       pg;
        logic       carry;
        a4     = '0;
        b4     = '0;
        g      = '0;
        p      = '0;
        c      = '0;
        gg     = 1'b0;
        pg     = 1'b0;
        diff_c = '0;
        carry  = 1'b1;
        for (int unsigned gi = 0; gi < GROUPS; gi++) begin
            a4   = t_c[gi*4 +: 4];
            b4   = ~d_reg[gi*4 +: 4];
            g    = a4 & b4;
            p    = a4 ^ b4;
            c[0] = carry;
            c[1] = g[0] | (p[0] & carry);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & carry);
            gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
            pg   = &p;
            diff_c[gi*4 +: 4] = p ^ c;
            carry = gg | (pg & carry);
        end
        // Top bit: T[WIDTH] plus the inverted zero-extension bit (always 1).
        // Generate = T[WIDTH], propagate = 1, so carry-out = T[WIDTH] | carry.
        no_borrow_c = t_c[WIDTH] | carry;
    end

    // Restoring step: keep the difference only when no borrow occurred.
    assign r_next_c = no_borrow_c ? diff_c : t_c[WIDTH-1:0];
    assign q_next_c = {q_reg[WIDTH-2:0], no_borrow_c};

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Division by zero finishes immediately.
                            state       <= FIN;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= RUN;
                            q_reg       <= dividend;
                            d_reg       <= divisor;
                            r_reg       <= '0;
                            cnt         <= '0;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end

                RUN: begin
                    r_reg <= r_next_c;
                    q_reg <= q_next_c;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= FIN;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next_c;
                        remainder <= r_next_c;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_divider.sv
// Self-checking bench for cla_seq_divider (WIDTH=4): directed scenarios,
// exhaustive non-zero-divisor sweep and random operands against an
// arithmetic reference (/ and %).
module tb_cla_seq_divider;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;

    cla_seq_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE and check the result, latency and pulse width.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
        logic [WIDTH-1:0] eq;
        logic [WIDTH-1:0] er;
        logic             ez;
        int               k;
        int               exp_k;
        if (b == 0) begin
            eq = '1; er = a; ez = 1'b1; exp_k = 0;
        end else begin
            eq = WIDTH'(a / b); er = WIDTH'(a % b); ez = 1'b0; exp_k = WIDTH;
        end
        start = 1'b1; dividend = a; divisor = b;
        step();
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            step();
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'(exp_k));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_fin"}, 32'(busy), 32'd0);
        chk({tag, "_quot"}, 32'(quotient), 32'(eq));
        chk({tag, "_rem"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        step();
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        chk({tag, "_quot_hold"}, 32'(quotient), 32'(eq));
        chk({tag, "_rem_hold"}, 32'(remainder), 32'(er));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        step();
        step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_quot", 32'(quotient), 32'd0);
        chk("reset_rem", 32'(remainder), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        step();

        // Directed basic cases.
        do_op(4'd13, 4'd3, "d13_3");
        do_op(4'd15, 4'd1, "d15_1");
        do_op(4'd3, 4'd7, "d3_7");
        do_op(4'd9, 4'd0, "d9_0");
        do_op(4'd8, 4'd2, "d8_2");
        do_op(4'd0, 4'd5, "d0_5");

        // Start during RUN is ignored; start held in FIN begins immediately.
        start = 1'b1; dividend = 4'd14; divisor = 4'd4;
        step();
        start = 1'b0;
        step();
        start = 1'b1; dividend = 4'd1; divisor = 4'd1;
        step();
        start = 1'b0;
        step();
        chk("ign_busy", 32'(busy), 32'd1);
        step();
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_quot", 32'(quotient), 32'd3);
        chk("ign_rem", 32'(remainder), 32'd2);
        start = 1'b1; dividend = 4'd10; divisor = 4'd5;
        step();
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done", 32'(done), 32'd0);
        chk("b2b_quot_hold", 32'(quotient), 32'd3);
        repeat (3) step();
        chk("b2b_done_early", 32'(done), 32'd0);
        step();
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_quot", 32'(quotient), 32'd2);
        chk("b2b_rem", 32'(remainder), 32'd0);
        chk("b2b_dbz", 32'(div_by_zero), 32'd0);
        step();
        chk("b2b_idle", 32'(done), 32'd0);

        // Asynchronous reset mid-operation.
        start = 1'b1; dividend = 4'd15; divisor = 4'd2;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_quot", 32'(quotient), 32'd0);
        chk("arst_rem", 32'(remainder), 32'd0);
        chk("arst_dbz", 32'(div_by_zero), 32'd0);
        step();
        rst = 1'b0;
        repeat (5) begin
            step();
            chk("arst_no_done", 32'(done), 32'd0);
            chk("arst_idle", 32'(busy), 32'd0);
        end
        do_op(4'd15, 4'd2, "d15_2");

        // Exhaustive sweep over non-zero divisors.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_op(WIDTH'(a), WIDTH'(b), "sweep");
            end
        end

        // Random operands, zero divisor included.
        for (int i = 0; i < 64; i++) begin
            do_op(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
